tu_link_aligner: RTL and testbench



---
 rtl/tu_align_pkg.sv | 27 ++
 rtl/tu_link_aligner_if.sv | 37 +++
 rtl/tu_frame_packer.sv | 48 ++++
 rtl/tu_link_aligner.sv | 155 +++++++++++++++
 tb/tb_tu_link_aligner.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tu_align_pkg.sv
// Shared types and constants for the trigger-unit link aligner.
// Holds the FSM state type, the default pattern bytes and the counter widths.
package tu_align_pkg;

    typedef enum logic [2:0] {
        HUNT,
        WAIT,
        CHECK,
        LOCKED,
        ASSEMBLE
    } align_state_e;

    localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hA5;
    localparam logic [7:0] DEF_FRAME_HDR     = 8'hBC;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 64;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int IDX_W          = 3;

    // Widths cover the full legal parameter ranges (LOCK_COUNT up to 255, the rest up to 15/16).
    localparam int MATCH_W = 8;
    localparam int WAIT_W  = 4;
    localparam int SLIP_W  = 4;
    localparam int LOSS_W  = 4;

endpackage

// File: rtl/tu_link_aligner_if.sv
// Link between the deserializer side and the aligner: raw bytes and restart in,
// bitslip control, lock status and assembled trigger words out.
interface tu_link_aligner_if;
    import tu_align_pkg::*;

    logic                align_start;
    logic [BYTE_W-1:0]   serdes_data_in;
    logic                bitslip;
    logic                bitslip_ena;
    logic [WORD_W-1:0]   trigger_data_out;
    logic                trigger_valid;
    logic [SLIP_W-1:0]   slip_count;
    logic                align_error;

    modport master (
        output align_start,
        output serdes_data_in,
        input  bitslip,
        input  bitslip_ena,
        input  trigger_data_out,
        input  trigger_valid,
        input  slip_count,
        input  align_error
    );

    modport slave (
        input  align_start,
        input  serdes_data_in,
        output bitslip,
        output bitslip_ena,
        output trigger_data_out,
        output trigger_valid,
        output slip_count,
        output align_error
    );

endinterface

// File: rtl/tu_frame_packer.sv
// Packs eight bytes MSB-first into a 64-bit word and presents it for one cycle
// on the edge after the eighth byte; the output is zero otherwise.
module tu_frame_packer
    import tu_align_pkg::*;
(
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic              load_en,
    input  logic              flush,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done,
    output logic              byte_last
);

    logic [WORD_W-1:0] shift_q;
    logic [IDX_W-1:0]  byte_idx;
    logic              full_q;

    // Tells the FSM the current byte completes the frame so it can leave ASSEMBLE on this edge.
    assign byte_last = load_en && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            shift_q   <= '0;
            byte_idx  <= '0;
            full_q    <= 1'b0;
            word      <= '0;
            word_done <= 1'b0;
        end else if (flush) begin
            shift_q   <= '0;
            byte_idx  <= '0;
            full_q    <= 1'b0;
            word      <= '0;
            word_done <= 1'b0;
        end else begin
            if (load_en) begin
                shift_q  <= {shift_q[WORD_W-BYTE_W-1:0], byte_in};
                byte_idx <= byte_idx + IDX_W'(1);
            end
            full_q    <= byte_last;
            word      <= full_q ? shift_q : '0;
            word_done <= full_q;
        end
    end

endmodule

// File: rtl/tu_link_aligner.sv
// Word-aligns the deserializer stream with bitslip, declares lock on a run of
// training bytes, then hands header-delimited frames to the packer.
module tu_link_aligner
    import tu_align_pkg::*;
#(
    parameter logic [7:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter logic [7:0] FRAME_HDR     = DEF_FRAME_HDR,
    parameter int         LOCK_COUNT    = 16,
    parameter int         SLIP_WAIT     = 4,
    parameter int         MAX_SLIPS     = 8,
    parameter int         LOSS_COUNT    = 4
) (
    input  logic         S_AXI_ACLK,
    input  logic         S_AXI_ARESET,
    tu_link_aligner_if.slave lnk
);

    localparam logic [MATCH_W-1:0] LOCK_V    = MATCH_W'(LOCK_COUNT);
    localparam logic [WAIT_W-1:0]  WAIT_V    = WAIT_W'(SLIP_WAIT);
    localparam logic [SLIP_W-1:0]  SLIP_LAST = SLIP_W'(MAX_SLIPS - 1);
    localparam logic [LOSS_W-1:0]  LOSS_V    = LOSS_W'(LOSS_COUNT);

    align_state_e       state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [LOSS_W-1:0]  bad_q, bad_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [SLIP_W-1:0]  slip_q, slip_d;
    logic               err_q, err_d;
    logic               bitslip_q, bitslip_d;
    logic               ena_q, ena_d;

    logic               is_train, is_hdr;
    logic               pk_last, pk_done;
    logic [WORD_W-1:0]  pk_word;

    assign is_train = (lnk.serdes_data_in == TRAIN_PATTERN);
    assign is_hdr   = (lnk.serdes_data_in == FRAME_HDR);

    tu_frame_packer u_packer (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .load_en      (state_q == ASSEMBLE),
        .flush        (lnk.align_start),
        .byte_in      (lnk.serdes_data_in),
        .word         (pk_word),
        .word_done    (pk_done),
        .byte_last    (pk_last)
    );

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= HUNT;
            match_q   <= '0;
            bad_q     <= '0;
            wait_q    <= '0;
            slip_q    <= '0;
            err_q     <= 1'b0;
            bitslip_q <= 1'b0;
            ena_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            bad_q     <= bad_d;
            wait_q    <= wait_d;
            slip_q    <= slip_d;
            err_q     <= err_d;
            bitslip_q <= bitslip_d;
            ena_q     <= ena_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (lnk.align_start) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT:     state_d = is_train ? CHECK : WAIT;
                WAIT:     if (wait_q <= WAIT_W'(1)) state_d = HUNT;
                CHECK: begin
                    if (!is_train)
                        state_d = HUNT;
                    else if (match_q + MATCH_W'(1) == LOCK_V)
                        state_d = LOCKED;
                end
                LOCKED: begin
                    if (is_train)
                        state_d = LOCKED;
                    else if (is_hdr)
                        state_d = ASSEMBLE;
                    else if (bad_q + LOSS_W'(1) == LOSS_V)
                        state_d = HUNT;
                end
                ASSEMBLE: if (pk_last) state_d = LOCKED;
                default:  state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        match_d   = match_q;
        bad_d     = bad_q;
        wait_d    = wait_q;
        slip_d    = slip_q;
        err_d     = err_q;
        bitslip_d = 1'b0;
        if (lnk.align_start) begin
            match_d = '0;
            bad_d   = '0;
            wait_d  = '0;
            slip_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (is_train) begin
                        match_d = MATCH_W'(1);
                    end else begin
                        bitslip_d = 1'b1;
                        wait_d    = WAIT_V;
                        // A full rotation without lock wraps the count and flags it.
                        if (slip_q == SLIP_LAST) begin
                            slip_d = '0;
                            err_d  = 1'b1;
                        end else begin
                            slip_d = slip_q + SLIP_W'(1);
                        end
                    end
                end
                WAIT:  wait_d = wait_q - WAIT_W'(1);
                CHECK: match_d = is_train ? match_q + MATCH_W'(1) : '0;
                LOCKED: begin
                    if (is_train || is_hdr)
                        bad_d = '0;
                    else if (bad_q + LOSS_W'(1) == LOSS_V)
                        bad_d = '0;
                    else
                        bad_d = bad_q + LOSS_W'(1);
                end
                default: ;
            endcase
        end
        // Lock status follows the state being entered, so it changes on the same edge as the state.
        ena_d = (state_d == LOCKED) || (state_d == ASSEMBLE);
    end

    assign lnk.bitslip          = bitslip_q;
    assign lnk.bitslip_ena      = ena_q;
    assign lnk.slip_count       = slip_q;
    assign lnk.align_error      = err_q;
    assign lnk.trigger_data_out = pk_word;
    assign lnk.trigger_valid    = pk_done;

endmodule

// File: tb/tb_tu_link_aligner.sv
// Self-checking bench for tu_link_aligner: a behavioural link model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_tu_link_aligner;
    import tu_align_pkg::*;

    localparam int         LOCK_COUNT = 16;
    localparam int         SLIP_WAIT  = 4;
    localparam int         MAX_SLIPS  = 8;
    localparam int         LOSS_COUNT = 4;
    localparam logic [7:0] TP  = 8'hA5;
    localparam logic [7:0] HDR = 8'hBC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tu_link_aligner_if lnk();

    tu_link_aligner #(
        .TRAIN_PATTERN (TP),
        .FRAME_HDR     (HDR),
        .LOCK_COUNT    (LOCK_COUNT),
        .SLIP_WAIT     (SLIP_WAIT),
        .MAX_SLIPS     (MAX_SLIPS),
        .LOSS_COUNT    (LOSS_COUNT)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .lnk          (lnk)
    );

    int n_run  = 0;
    int n_fail = 0;
    bit run    = 1'b0;
    int n_slip_pulses = 0;
    int n_valid       = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural link model: settle countdown, match run, lock flag, frame byte queue.
    int         m_settle, m_matches, m_bad, m_slips;
    bit         m_locked, m_in_frame, m_err, m_pend;
    logic [63:0] m_pend_word;
    logic [7:0] m_frame[$];
    bit         e_bitslip, e_ena, e_valid;
    logic [63:0] e_word;

    function automatic void model_clear();
        m_settle = 0; m_matches = 0; m_bad = 0; m_slips = 0;
        m_locked = 0; m_in_frame = 0; m_err = 0; m_pend = 0;
        m_pend_word = '0;
        m_frame.delete();
        e_bitslip = 0; e_ena = 0; e_valid = 0; e_word = '0;
    endfunction

    function automatic void model_step(input bit start, input logic [7:0] d);
        e_bitslip = 0;
        e_valid   = m_pend;
        e_word    = m_pend ? m_pend_word : 64'd0;
        m_pend    = 0;
        if (start) begin
            model_clear();
            return;
        end
        if (m_settle > 0) begin
            m_settle--;
        end else if (m_locked && m_in_frame) begin
            m_frame.push_back(d);
            if (m_frame.size() == 8) begin
                m_pend_word = '0;
                foreach (m_frame[i]) m_pend_word = (m_pend_word << 8) | 64'(m_frame[i]);
                m_pend = 1;
                m_frame.delete();
                m_in_frame = 0;
            end
        end else if (m_locked) begin
            if (d == TP) m_bad = 0;
            else if (d == HDR) begin m_bad = 0; m_in_frame = 1; end
            else begin
                m_bad++;
                if (m_bad == LOSS_COUNT) begin m_bad = 0; m_locked = 0; end
            end
        end else if (m_matches == 0) begin
            if (d == TP) m_matches = 1;
            else begin
                e_bitslip = 1;
                m_settle  = SLIP_WAIT;
                m_slips   = (m_slips + 1) % MAX_SLIPS;
                if (m_slips == 0) m_err = 1;
            end
        end else if (d == TP) begin
            m_matches++;
            if (m_matches == LOCK_COUNT) begin m_locked = 1; m_matches = 0; end
        end else begin
            m_matches = 0;
        end
        e_ena = m_locked;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_clear();
        else     model_step(lnk.align_start, lnk.serdes_data_in);
    end

    always @(negedge clk) begin
        if (run) begin
            check("bitslip",       64'(lnk.bitslip),     64'(e_bitslip));
            check("bitslip_ena",   64'(lnk.bitslip_ena), 64'(e_ena));
            check("trigger_valid", 64'(lnk.trigger_valid), 64'(e_valid));
            check("trigger_data",  lnk.trigger_data_out, e_word);
            check("slip_count",    64'(lnk.slip_count),  64'(m_slips));
            check("align_error",   64'(lnk.align_error), 64'(m_err));
            if (lnk.bitslip)       n_slip_pulses++;
            if (lnk.trigger_valid) n_valid++;
        end
    end

    task automatic send(input logic [7:0] b, input bit start = 1'b0);
        lnk.serdes_data_in = b;
        lnk.align_start    = start;
        @(posedge clk);
        #1;
        lnk.align_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bitslip"}, 64'(lnk.bitslip),       64'd0);
        check({tag, "_ena"},     64'(lnk.bitslip_ena),   64'd0);
        check({tag, "_valid"},   64'(lnk.trigger_valid), 64'd0);
        check({tag, "_data"},    lnk.trigger_data_out,   64'd0);
        check({tag, "_slips"},   64'(lnk.slip_count),    64'd0);
        check({tag, "_err"},     64'(lnk.align_error),   64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int lock_cyc;
        int pulse_cyc[$];
        logic [7:0] frame_a[8];

        lnk.align_start    = 1'b0;
        lnk.serdes_data_in = 8'h00;
        #1;
        do_reset();
        run = 1'b1;

        // 1: aligned stream locks after 16 matches with no slips
        n_slip_pulses = 0;
        repeat (15) send(TP);
        check("t1_ena_after15", 64'(lnk.bitslip_ena), 64'd0);
        send(TP);
        check("t1_ena_after16", 64'(lnk.bitslip_ena), 64'd1);
        check("t1_slip_count",  64'(lnk.slip_count),  64'd0);
        check("t1_pulses",      64'(n_slip_pulses),   64'd0);

        // 2: rotated pattern until the third slip, aligned afterwards
        do_reset();
        seen = 0;
        lock_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            send(seen < 3 ? 8'h2D : TP);
            if (lnk.bitslip) begin
                seen++;
                pulse_cyc.push_back(c);
            end
            if (lnk.bitslip_ena && lock_cyc < 0) lock_cyc = c;
        end
        check("t2_pulses",     64'(seen),           64'd3);
        check("t2_slip_count", 64'(lnk.slip_count), 64'd3);
        check("t2_lock_cycle", 64'(lock_cyc),       64'd31);
        if (pulse_cyc.size() == 3) begin
            check("t2_first_pulse", 64'(pulse_cyc[0]),                64'd1);
            check("t2_gap1",        64'(pulse_cyc[1] - pulse_cyc[0]), 64'd5);
            check("t2_gap2",        64'(pulse_cyc[2] - pulse_cyc[1]), 64'd5);
        end

        // 3: frames, latency, in-frame control bytes, back-to-back, zero word
        n_valid = 0;
        send(HDR);
        for (int b = 1; b <= 8; b++) send(8'(b));
        check("t3_valid_early", 64'(lnk.trigger_valid), 64'd0);
        send(TP);
        check("t3_valid", 64'(lnk.trigger_valid), 64'd1);
        check("t3_word",  lnk.trigger_data_out,   64'h0102030405060708);
        send(TP);
        check("t3_valid_off", 64'(lnk.trigger_valid), 64'd0);
        check("t3_word_off",  lnk.trigger_data_out,   64'd0);
        frame_a = '{8'hA5, 8'hBC, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
        send(HDR);
        for (int i = 0; i < 8; i++) send(frame_a[i]);
        send(HDR);
        check("t3_b2b_valid", 64'(lnk.trigger_valid), 64'd1);
        check("t3_b2b_word",  lnk.trigger_data_out,   64'hA5BC00FF11223344);
        repeat (8) send(8'h00);
        send(TP);
        check("t3_zero_valid", 64'(lnk.trigger_valid), 64'd1);
        check("t3_zero_word",  lnk.trigger_data_out,   64'd0);
        send(TP);
        check("t3_word_count", 64'(n_valid), 64'd3);

        // 4: illegal bytes, counter cleared by training byte, then lock loss
        repeat (3) send(8'h00);
        send(TP);
        repeat (3) send(8'h00);
        check("t4_ena_after3", 64'(lnk.bitslip_ena), 64'd1);
        send(8'h00);
        check("t4_ena_after4", 64'(lnk.bitslip_ena), 64'd0);
        check("t4_slip_kept",  64'(lnk.slip_count),  64'd3);
        send(8'h00);
        check("t4_slip_resume", 64'(lnk.bitslip),    64'd1);
        check("t4_slip_count",  64'(lnk.slip_count), 64'd4);

        // 5: full rotation without lock wraps slip_count and sets align_error
        do_reset();
        repeat (35) send(8'h00);
        check("t5_err_before",   64'(lnk.align_error), 64'd0);
        check("t5_slips_before", 64'(lnk.slip_count),  64'd7);
        send(8'h00);
        check("t5_err_set",   64'(lnk.align_error), 64'd1);
        check("t5_slip_wrap", 64'(lnk.slip_count),  64'd0);
        repeat (3) send(8'h00);
        check("t5_err_sticky", 64'(lnk.align_error), 64'd1);
        send(8'h00, 1'b1);
        check("t5_err_cleared", 64'(lnk.align_error), 64'd0);
        check("t5_slip_cleared", 64'(lnk.slip_count), 64'd0);
        send(8'h00);
        check("t5_slip_restart", 64'(lnk.slip_count), 64'd1);

        // 6: restart and async reset in the middle of a frame
        do_reset();
        repeat (16) send(TP);
        n_valid = 0;
        send(HDR);
        send(8'h11); send(8'h22); send(8'h33);
        send(TP, 1'b1);
        check("t6_start_ena", 64'(lnk.bitslip_ena), 64'd0);
        repeat (16) send(TP);
        check("t6_relock", 64'(lnk.bitslip_ena), 64'd1);
        check("t6_no_word_after_start", 64'(n_valid), 64'd0);
        send(HDR);
        send(8'h44); send(8'h55); send(8'h66);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) send(TP);
        check("t6_no_word_after_reset", 64'(n_valid), 64'd0);

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
